// File: rtl/ddram_loader_pkg.sv
// Shared types for the DDR byte-port ROM loader: FIFO entry layout and write FSM states.
package ddram_loader_pkg;

    typedef struct packed {
        logic [27:0] addr;
        logic [7:0]  data;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACK,
        GAP
    } wr_state_t;

endpackage

// File: rtl/ddram_loader_fifo.sv
// Single-clock FIFO of {addr, data} entries; show-ahead head, push/pop take effect next cycle.
// Push when full is dropped and latches a sticky overflow flag; pop when empty is ignored.
module ddram_loader_fifo
    import ddram_loader_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fifo_entry_t              din,
    input  logic                     pop,
    output fifo_entry_t              dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    fifo_entry_t   mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          push_ok;
    logic          pop_ok;
    logic          overflow;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointers carry one extra bit so full and empty stay distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ddram_rom_loader.sv
// Turns HPS ioctl download strobes into single edge-triggered byte writes; core reads pass through otherwise.
// Write issue >= 1 cycle after push, >= 4 cycles between writes; HPS held by registered ioctl_wait.
module ddram_rom_loader
    import ddram_loader_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [27:0] ADDR_OFFSET = 28'h0
) (
    input  logic        DDRAM_CLK,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [27:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        load_done,
    input  logic [27:0] core_addr,
    input  logic        core_rd,
    output logic [7:0]  core_dout,
    output logic        core_ready,
    input  logic        mem_busy,
    output logic [27:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    output logic        mem_rd,
    input  logic [7:0]  mem_dout,
    input  logic        mem_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wr_state_t     state;
    wr_state_t     state_nxt;
    fifo_entry_t   push_ent;
    fifo_entry_t   head;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_nxt;
    logic          pop;
    logic          push_ok;
    logic          load_mode;
    logic          dl_seen;
    logic          done_cond;
    logic [27:0]   wr_addr;
    logic [7:0]    wr_din;

    assign push_ent.addr = ioctl_addr + ADDR_OFFSET;
    assign push_ent.data = ioctl_dout;

    ddram_loader_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (DDRAM_CLK),
        .rst_n (reset_n),
        .push  (ioctl_wr),
        .din   (push_ent),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && mem_ready) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   if (!mem_ready) state_nxt = ACK;
            ACK:     if (mem_ready)  state_nxt = GAP;
            // One idle-bus cycle lets the port's edge detector see we low before the next write.
            GAP:     if (!mem_busy)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign push_ok   = ioctl_wr & ~fifo_full;
    assign count_nxt = fifo_count + CW'(push_ok) - CW'(pop);
    assign done_cond = ~ioctl_download & fifo_empty & (state == IDLE) & dl_seen;

    always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_addr    <= '0;
            wr_din     <= '0;
            ioctl_wait <= 1'b0;
            dl_seen    <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                wr_addr <= head.addr;
                wr_din  <= head.data;
            end
            // Wait is raised off next-cycle occupancy, leaving two slots for strobes in flight.
            ioctl_wait <= (count_nxt >= CW'(FIFO_DEPTH - 2));
            load_done  <= done_cond;
            if (done_cond)
                dl_seen <= 1'b0;
            else if (ioctl_download)
                dl_seen <= 1'b1;
        end
    end

    assign load_mode  = ioctl_download | ~fifo_empty | (state != IDLE);
    assign mem_addr   = load_mode ? wr_addr : core_addr;
    assign mem_din    = wr_din;
    assign mem_we     = (state == ISSUE);
    assign mem_rd     = load_mode ? 1'b0 : core_rd;
    assign core_dout  = mem_dout;
    assign core_ready = load_mode ? 1'b0 : mem_ready;

endmodule
